regwrite_arbiter: RTL
=====================

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter ZERO_DROP, default 1: when 1, a granted write to register 0 completes its handshake but never asserts reg_wr.
REQ-002 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  4  write-port request, one bit per requester (index 0..3).
REQ-005 dest0, dest1, dest2, dest3  input  5 each  destination register number of requester 0..3.
REQ-006 sel  output  2  select code driving the 4:1 5-bit destination mux (00 = requester 0 ... 11 = requester 3).
REQ-007 gnt  output  4  one-hot, one-cycle acknowledge to the served requester.
REQ-008 reg_wr  output  1  register-bank write enable.
REQ-009 wr_addr  output  5  registered destination captured for the write in progress.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT, WRITE.
REQ-012 In IDLE with req != 0, the next state SHALL be GRANT; with req == 0 it SHALL remain IDLE.
REQ-013 On entry to GRANT, the block SHALL latch the winner index into sel and the winner's dest into wr_addr; both SHALL hold until the next arbitration.
REQ-014 GRANT SHALL always be followed by WRITE, one cycle later.
REQ-015 In WRITE, gnt[sel] SHALL be 1 for exactly that cycle; reg_wr SHALL be 1 unless ZERO_DROP=1 and wr_addr == 0.
REQ-016 From WRITE, the block SHALL go to GRANT if any req bit other than the one just served is high, otherwise to IDLE.
REQ-017 Arbitration SHALL be round-robin: the search starts at (last_served+1) mod 4, wrapping 3 -> 0; last_served resets to 3, so index 0 has top priority after reset.
REQ-018 An arbitration leaving WRITE SHALL mask the requester just served, even if its req is still high that cycle.
REQ-019 A requester SHALL hold req and dest stable until it sees its gnt bit, and deassert req in the following cycle.
REQ-020 Changes on dest after capture SHALL NOT affect wr_addr.
REQ-021 req withdrawn during GRANT SHALL NOT cancel the operation: WRITE, gnt and reg_wr occur as committed.
REQ-022 Latency: req first seen high in IDLE at edge k -> GRANT from k, WRITE (gnt, reg_wr) in cycle after k+1, busy high from k.
REQ-023 Throughput with back-to-back requests from different requesters SHALL be one write per 2 cycles (GRANT, WRITE, GRANT, ...).
REQ-024 gnt, reg_wr SHALL be 0 in IDLE and GRANT; busy SHALL be 1 in GRANT and WRITE.

Reset
REQ-025 With reset low at a rising edge: state = IDLE, sel = 00, gnt = 0000, reg_wr = 0, wr_addr = 00000, busy = 0, last_served = 3.
REQ-026 Reset asserted during GRANT or WRITE SHALL abort the operation with no reg_wr pulse in the following cycle; the aborted request is not remembered.
REQ-027 After reset releases, the first arbitration SHALL follow REQ-012 using the then-current req.

Verification
REQ-028 Single request: req=0010, dest1=5'd17 -> GRANT with sel=01, wr_addr=17; next cycle gnt=0010, reg_wr=1; then IDLE, busy=0.
REQ-029 All four requesters held high from reset -> grants in order 0,1,2,3,0, each WRITE cycle 2 cycles apart, no grant repeated consecutively.
REQ-030 Zero-drop: req=1000, dest3=0, ZERO_DROP=1 -> sel=11, gnt=1000 in WRITE, reg_wr=0 throughout; with ZERO_DROP=0 -> reg_wr=1.
REQ-031 Dest change after capture: req=0001, dest0=9, dest0 changed to 4 during GRANT -> wr_addr=9 in WRITE.
REQ-032 Mask on exit: req=0011, requester 0 served, req[0] still high in its WRITE cycle -> next GRANT has sel=01, not 00.
REQ-033 Reset mid-operation: reset low during GRANT for requester 2 -> next cycle all outputs at reset values, gnt[2] and reg_wr never pulse.

Source files
------------

// File: rtl/regwrite_arbiter.sv
//==============================================================================
// Module      : regwrite_arbiter
// Description : Four-requester round-robin arbiter for one register-bank write
//               port. Each winner takes a GRANT cycle and then a WRITE cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regwrite_arbiter #(
    parameter int ZERO_DROP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [4:0] dest0,
    input  logic [4:0] dest1,
    input  logic [4:0] dest2,
    input  logic [4:0] dest3,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       reg_wr,
    output logic [4:0] wr_addr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_sel;
    logic [4:0] r_wr_addr;
    logic [1:0] r_last_served;

    logic [3:0] w_served_mask;
    logic [3:0] w_cand;
    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_idx;
    logic [4:0] w_dest;

    // The requester being served in WRITE is excluded from the next search,
    // since its req is still legally high during that cycle.
    always_comb begin
        w_served_mask = (r_state == WRITE) ? (4'b0001 << r_sel) : 4'b0000;
        w_cand        = req & ~w_served_mask;
        w_found       = 1'b0;
        w_winner      = r_last_served;
        w_idx         = r_last_served;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_last_served + 2'(i + 1);
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        case (w_winner)
            2'd0:    w_dest = dest0;
            2'd1:    w_dest = dest1;
            2'd2:    w_dest = dest2;
            default: w_dest = dest3;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_found ? GRANT : IDLE;
            GRANT:   w_state_next = WRITE;
            WRITE:   w_state_next = w_found ? GRANT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_sel         <= 2'd0;
            r_wr_addr     <= 5'd0;
            r_last_served <= 2'd3;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == GRANT) begin
                r_sel     <= w_winner;
                r_wr_addr <= w_dest;
            end
            // Priority only advances once a grant commits to its WRITE cycle.
            if (r_state == GRANT) begin
                r_last_served <= r_sel;
            end
        end
    end

    assign sel     = r_sel;
    assign wr_addr = r_wr_addr;
    assign busy    = (r_state != IDLE);
    assign gnt     = (r_state == WRITE) ? (4'b0001 << r_sel) : 4'b0000;
    assign reg_wr  = (r_state == WRITE) && !((ZERO_DROP != 0) && (r_wr_addr == 5'd0));

endmodule

`default_nettype wire
